// File: rtl/pump_pkg.sv
// Shared encodings for the pump sequencer, its timers and benches.
package pump_pkg;

    typedef enum logic [1:0] {
        CMD_TURN_OFF   = 2'b00,
        CMD_TURN_ON    = 2'b01,
        CMD_STOP_PUMP  = 2'b10,
        CMD_START_PUMP = 2'b11
    } pump_cmd_t;

    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_STANDBY = 2'b01,
        ST_RUNNING = 2'b10,
        ST_FAULT   = 2'b11
    } pump_state_t;

    // Width able to hold the larger of the two minimum times; never below 1 bit.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int max_v;
        max_v = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (max_v > 0) ? $clog2(max_v + 1) : 1;
    endfunction

endpackage

// File: rtl/pump_timer.sv
// Loadable saturating down-counter. zero flags that the count is zero once this
// edge's decrement has been applied, so a load of N expires exactly N edges later.
module pump_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Counter register: load wins over decrement, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r <= {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pump_sequencer.sv
// Pump start/stop sequencer: enforces minimum on/off times, a one-edge gap
// between commands and fault lock-out until the system is re-armed.
module pump_sequencer
    import pump_pkg::*;
#(
    parameter int MIN_ON_CYCLES  = 8,
    parameter int MIN_OFF_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       demand,
    input  logic       fault,
    output logic [1:0] command,
    output logic       update,
    output logic       running,
    output logic       faulted
);

    localparam int TW = timer_width(MIN_ON_CYCLES, MIN_OFF_CYCLES);
    localparam logic [TW-1:0] ON_LOAD  = TW'(MIN_ON_CYCLES);
    localparam logic [TW-1:0] OFF_LOAD = TW'(MIN_OFF_CYCLES);

    pump_state_t state_r, next_state_s;
    pump_cmd_t   command_r, next_cmd_s;
    logic        update_r, gap_r, running_r, faulted_r;
    logic        issue_s, run_load_s, cool_load_s;
    logic        run_zero_s, cool_zero_s;

    pump_timer #(.WIDTH(TW)) u_run_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (run_load_s),
        .load_value (ON_LOAD),
        .dec        (state_r == ST_RUNNING),
        .zero       (run_zero_s)
    );

    pump_timer #(.WIDTH(TW)) u_cool_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (cool_load_s),
        .load_value (OFF_LOAD),
        .dec        (state_r != ST_RUNNING),
        .zero       (cool_zero_s)
    );

    // Next-state and command selection; priority is fault, then enable, then demand.
    always_comb begin
        next_state_s = state_r;
        next_cmd_s   = command_r;
        issue_s      = 1'b0;
        run_load_s   = 1'b0;
        cool_load_s  = 1'b0;
        if (gap_r) begin
            next_state_s = state_r;
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (enable && !fault) begin
                        next_state_s = ST_STANDBY;
                        next_cmd_s   = CMD_TURN_ON;
                        issue_s      = 1'b1;
                    end else begin
                        next_state_s = ST_OFF;
                    end
                end
                ST_STANDBY: begin
                    if (fault) begin
                        next_state_s = ST_FAULT;
                        next_cmd_s   = CMD_TURN_OFF;
                        issue_s      = 1'b1;
                    end else if (!enable) begin
                        next_state_s = ST_OFF;
                        next_cmd_s   = CMD_TURN_OFF;
                        issue_s      = 1'b1;
                    end else if (demand && cool_zero_s) begin
                        next_state_s = ST_RUNNING;
                        next_cmd_s   = CMD_START_PUMP;
                        issue_s      = 1'b1;
                        run_load_s   = 1'b1;
                    end else begin
                        next_state_s = ST_STANDBY;
                    end
                end
                ST_RUNNING: begin
                    // Any exit from RUNNING stops the pump, so the off-time starts here.
                    if (fault) begin
                        next_state_s = ST_FAULT;
                        next_cmd_s   = CMD_TURN_OFF;
                        issue_s      = 1'b1;
                        cool_load_s  = 1'b1;
                    end else if (run_zero_s && !enable) begin
                        next_state_s = ST_OFF;
                        next_cmd_s   = CMD_TURN_OFF;
                        issue_s      = 1'b1;
                        cool_load_s  = 1'b1;
                    end else if (run_zero_s && !demand) begin
                        next_state_s = ST_STANDBY;
                        next_cmd_s   = CMD_STOP_PUMP;
                        issue_s      = 1'b1;
                        cool_load_s  = 1'b1;
                    end else begin
                        next_state_s = ST_RUNNING;
                    end
                end
                ST_FAULT: begin
                    if (!fault && !enable) begin
                        next_state_s = ST_OFF;
                    end else begin
                        next_state_s = ST_FAULT;
                    end
                end
                default: begin
                    next_state_s = ST_OFF;
                end
            endcase
        end
    end

    // State, command and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_OFF;
            command_r <= CMD_TURN_OFF;
            update_r  <= 1'b0;
            gap_r     <= 1'b0;
            running_r <= 1'b0;
            faulted_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            command_r <= next_cmd_s;
            update_r  <= issue_s;
            gap_r     <= issue_s;
            running_r <= (next_state_s == ST_RUNNING);
            faulted_r <= (next_state_s == ST_FAULT);
        end
    end

    assign command = command_r;
    assign update  = update_r;
    assign running = running_r;
    assign faulted = faulted_r;

endmodule

// File: tb/tb_pump_sequencer.sv
// Scoreboard bench for pump_sequencer: expected (edge, command) issues are queued
// as stimulus is driven and matched against every update strobe.
module tb_pump_sequencer;
    import pump_pkg::*;

    typedef struct {
        int         edge_no;
        logic [1:0] cmd;
    } exp_issue_t;

    logic       clk = 1'b0;
    logic       reset, enable, demand, fault;
    logic [1:0] command;
    logic       update, running, faulted;

    int         edge_cnt = 0;
    int         n_compared = 0;
    int         n_mismatched = 0;
    exp_issue_t exp_q[$];

    pump_sequencer #(.MIN_ON_CYCLES(8), .MIN_OFF_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .demand  (demand),
        .fault   (fault),
        .command (command),
        .update  (update),
        .running (running),
        .faulted (faulted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared = n_compared + 1;
        if (got !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic expect_issue(input int e, input logic [1:0] c);
        exp_issue_t item;
        item.edge_no = e;
        item.cmd     = c;
        exp_q.push_back(item);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (update === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_update", 32'(command), 32'hFFFF_FFFF);
            end else begin
                exp_issue_t item;
                item = exp_q.pop_front();
                check_eq("issue_edge", 32'(edge_cnt), 32'(item.edge_no));
                check_eq("issue_cmd", 32'(command), 32'(item.cmd));
            end
        end
    end

    initial begin
        int b, s, t, r, e, a;
        reset = 1'b1; enable = 1'b0; demand = 1'b0; fault = 1'b0;
        wait_edges(3);
        check_eq("rst_command", 32'(command), 32'(CMD_TURN_OFF));
        check_eq("rst_update", 32'(update), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_faulted", 32'(faulted), 32'd0);

        // Power-up straight into a run, then minimum on/off timing.
        enable = 1'b1; demand = 1'b1;
        b = edge_cnt;
        reset = 1'b0;
        expect_issue(b + 1, CMD_TURN_ON);
        expect_issue(b + 3, CMD_START_PUMP);
        wait_edges(3);
        check_eq("running_after_start", 32'(running), 32'd1);
        s = b + 3;
        wait_edges(2);
        demand = 1'b0;
        expect_issue(s + 8, CMD_STOP_PUMP);
        wait_edges(5);
        check_eq("min_on_hold", 32'(running), 32'd1);
        check_eq("min_on_cmd", 32'(command), 32'(CMD_START_PUMP));
        wait_edges(1);
        check_eq("stopped", 32'(running), 32'd0);
        t = s + 8;
        wait_edges(1);
        demand = 1'b1;
        expect_issue(t + 4, CMD_START_PUMP);
        wait_edges(2);
        check_eq("cooldown_hold", 32'(running), 32'd0);
        wait_edges(1);
        check_eq("restart", 32'(running), 32'd1);
        r = t + 4;

        // One-cycle fault while running locks out until re-armed.
        wait_edges(3);
        fault = 1'b1;
        expect_issue(r + 4, CMD_TURN_OFF);
        wait_edges(1);
        fault = 1'b0;
        check_eq("fault_entered", 32'(faulted), 32'd1);
        check_eq("fault_not_running", 32'(running), 32'd0);
        wait_edges(3);
        check_eq("fault_latched", 32'(faulted), 32'd1);
        enable = 1'b0;
        wait_edges(1);
        check_eq("fault_rearmed", 32'(faulted), 32'd0);
        check_eq("rearm_cmd_hold", 32'(command), 32'(CMD_TURN_OFF));

        // Fault and enable drop together in STANDBY: fault wins.
        demand = 1'b0; enable = 1'b1;
        e = edge_cnt + 1;
        expect_issue(e, CMD_TURN_ON);
        wait_edges(2);
        fault = 1'b1; enable = 1'b0;
        expect_issue(e + 2, CMD_TURN_OFF);
        wait_edges(1);
        fault = 1'b0;
        check_eq("fault_priority", 32'(faulted), 32'd1);
        check_eq("strobe_high", 32'(update), 32'd1);
        wait_edges(1);
        check_eq("strobe_width", 32'(update), 32'd0);
        wait_edges(2);
        check_eq("fault_cleared", 32'(faulted), 32'd0);

        // Reset on the edge right after a startPump issue.
        enable = 1'b1; demand = 1'b1;
        a = edge_cnt;
        expect_issue(a + 1, CMD_TURN_ON);
        expect_issue(a + 3, CMD_START_PUMP);
        wait_edges(3);
        reset = 1'b1;
        wait_edges(1);
        check_eq("midrst_update", 32'(update), 32'd0);
        check_eq("midrst_command", 32'(command), 32'(CMD_TURN_OFF));
        check_eq("midrst_running", 32'(running), 32'd0);

        // enable drop while the run timer is active is deferred to its expiry.
        b = edge_cnt;
        reset = 1'b0;
        expect_issue(b + 1, CMD_TURN_ON);
        expect_issue(b + 3, CMD_START_PUMP);
        s = b + 3;
        wait_edges(5);
        enable = 1'b0;
        expect_issue(s + 8, CMD_TURN_OFF);
        wait_edges(5);
        check_eq("enable_ignored", 32'(running), 32'd1);
        wait_edges(1);
        check_eq("off_after_min_on", 32'(running), 32'd0);
        check_eq("off_not_faulted", 32'(faulted), 32'd0);
        wait_edges(4);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
